video_timing_normalize: RTL and testbench
=========================================

# video_timing_normalize

Parametrised successor to the fixed 2-cycle sync/data alignment stage in the detect path. Delays vsync, hsync, DE and pixel data by a common programmable latency, normalises vsync/hsync to active-high (auto-detected or forced polarity), and measures frame timing (h total, h active, v total, v active) with a lock flag. Sits between the video input pins and the downstream DMA write logic.

## Interface

- pDATA_WIDTH, 16, pixel data width
- pDELAY, 2, pipeline latency in cycles for all signals; legal range 2..16
- pCNT_WIDTH, 12, width of period and measurement counters

Ports:

- i_clk  input  1  pixel clock; one clock, all logic on the rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_vsyn  input  1  raw vsync, either polarity
- i_hsyn  input  1  raw hsync, either polarity
- i_de  input  1  data enable, active-high
- i_video_data  input  pDATA_WIDTH  pixel data
- i_auto_pol  input  1  1 = auto-detect sync polarity; 0 = use i_force_inv
- i_force_inv  input  2  bit0 invert vsync, bit1 invert hsync (used when i_auto_pol=0)
- o_vsyn  output  1  vsync, active-high, delayed pDELAY
- o_hsyn  output  1  hsync, active-high, delayed pDELAY
- o_de  output  1  DE, delayed pDELAY, never inverted
- o_video_data  output  pDATA_WIDTH  data, delayed pDELAY
- o_vs_inv, o_hs_inv  output  1 each  polarity currently applied (1 = inverting)
- o_h_total, o_h_active, o_v_total, o_v_active  output  pCNT_WIDTH each  last measured timing
- o_lock  output  1  timing stable

## Operation

- Reset: every output 0; polarity registers 0 (non-inverting); all counters 0; o_lock 0.
- Delay line: shift registers of depth pDELAY for vsyn, hsyn, de, data; reset to 0.
- Auto polarity, per sync signal independently: count cycles high (H) and low (L) between consecutive raw rising edges; at each rising edge, if H > L set inv=1, if L > H set inv=0, if H == L keep; then clear H/L. H/L saturate at all-ones. First rising edge after reset only starts a period (no decision).
- Inversion is applied at the output: o_xsyn = delayed_raw XOR inv. Decision timing relative to the delayed stream is not glitch-protected; a change appears on the output the cycle after the decision.
- i_auto_pol=0: inv = i_force_inv bit, registered (one-cycle effect); H/L counters keep running so switching back to auto needs no restart.
- Measurement on normalised outputs (o_hsyn/o_vsyn/o_de):
  - h_total: cycles between consecutive o_hsyn rising edges.
  - h_active: o_de high cycles within one line.
  - v_total: o_hsyn rising edges between consecutive o_vsyn rising edges.
  - v_active: lines containing at least one o_de cycle in that frame.
  - All counters saturate at 2^pCNT_WIDTH-1; no wrap.
- Update: o_h_total/o_h_active load on each o_hsyn rising edge; o_v_total/o_v_active on each o_vsyn rising edge. Simultaneous hsync and vsync edges: the line is counted into the ending frame first, then both counters restart.
- Lock: at each vsync rising edge compare new h_total and v_total against previously latched values; 2 consecutive matching frames set o_lock; any mismatch, or a polarity register change, clears o_lock immediately (next cycle).

## Timing

- Data/DE path latency exactly pDELAY cycles; o_hsyn/o_vsyn aligned to o_de/o_video_data.
- Measurement outputs valid 1 cycle after the relevant o_hsyn/o_vsyn rising edge.
- o_lock asserts 1 cycle after the 2nd matching vsync edge.
- Asynchronous reset mid-frame: all state clears immediately; measurement restarts at the next edges.

## Test plan

- Active-high syncs, h_total 100, hsync 10 high, DE 80, v_total 20, vsync 2 lines, i_auto_pol=1 -> o_hs_inv=o_vs_inv=0, o_h_total=100, o_h_active=80, o_v_total=20, o_v_active=set DE lines (16), o_lock=1 after 3rd vsync edge.
- Same timing, syncs active-low -> after first full periods o_hs_inv=o_vs_inv=1, o_hsyn high exactly 10 cycles per line, o_lock again after 2 matching frames following the last polarity change.
- Data ramp 0,1,2..., pDELAY=2 and pDELAY=5 -> o_video_data equals input delayed exactly 2 / 5 cycles, o_de aligned.
- i_auto_pol=0, i_force_inv=2'b10 with active-high hsync -> hsync inverted, vsync passed, polarity registers follow within 1 cycle.
- Change h_total 100 -> 104 mid-run -> o_lock clears after next vsync edge, reasserts after 2 matching 104-cycle frames; h_total 5000 with pCNT_WIDTH=12 -> o_h_total=4095.
- Reset asserted mid-line -> all outputs 0 same cycle; after release first measurement reflects a full period only.

Source files
------------

// File: rtl/video_timing_normalize.sv
// Video input conditioning: common-latency delay line for sync/DE/data, active-high
// sync normalisation (auto-detected or forced polarity) and frame timing measurement.
module video_timing_normalize #(
    parameter int pDATA_WIDTH = 16,
    parameter int pDELAY      = 2,
    parameter int pCNT_WIDTH  = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_vsyn,
    input  logic                   i_hsyn,
    input  logic                   i_de,
    input  logic [pDATA_WIDTH-1:0] i_video_data,
    input  logic                   i_auto_pol,
    input  logic [1:0]             i_force_inv,
    output logic                   o_vsyn,
    output logic                   o_hsyn,
    output logic                   o_de,
    output logic [pDATA_WIDTH-1:0] o_video_data,
    output logic                   o_vs_inv,
    output logic                   o_hs_inv,
    output logic [pCNT_WIDTH-1:0]  o_h_total,
    output logic [pCNT_WIDTH-1:0]  o_h_active,
    output logic [pCNT_WIDTH-1:0]  o_v_total,
    output logic [pCNT_WIDTH-1:0]  o_v_active,
    output logic                   o_lock
);

    localparam int LP_STG = pDELAY - 1;
    typedef logic [pCNT_WIDTH-1:0] cnt_t;
    localparam cnt_t LP_CNT_ZERO = {pCNT_WIDTH{1'b0}};
    localparam cnt_t LP_CNT_ONE  = {{(pCNT_WIDTH-1){1'b0}}, 1'b1};
    localparam cnt_t LP_CNT_MAX  = {pCNT_WIDTH{1'b1}};

    function automatic cnt_t sat_inc(input cnt_t v);
        if (v == LP_CNT_MAX) sat_inc = v;
        else                 sat_inc = v + LP_CNT_ONE;
    endfunction

    logic [LP_STG-1:0]      vs_dly_r, hs_dly_r, de_dly_r;
    logic [pDATA_WIDTH-1:0] data_dly_r [LP_STG];

    // index 0 = vsync, 1 = hsync, matching the i_force_inv bit order
    logic [1:0] raw_s, rise_s, raw_prev_r, pol_seen_r, inv_r, inv_nxt_s;
    logic       pol_chg_s;
    cnt_t       hi_cnt_r [2];
    cnt_t       lo_cnt_r [2];

    logic hs_o_prev_r, vs_o_prev_r, hs_rise_s, vs_rise_s;
    logic h_seen_r, v_seen_r, line_de_r, lk_valid_r, lock_match_s;
    cnt_t hcnt_r, dcnt_r, vcnt_r, vact_r, lk_h_r, lk_v_r;
    cnt_t h_new_s, v_new_s, va_new_s;

    assign raw_s     = {i_hsyn, i_vsyn};
    assign rise_s    = raw_s & ~raw_prev_r;
    assign pol_chg_s = |(inv_nxt_s ^ inv_r);
    assign o_vs_inv  = inv_r[0];
    assign o_hs_inv  = inv_r[1];
    assign hs_rise_s = o_hsyn & ~hs_o_prev_r;
    assign vs_rise_s = o_vsyn & ~vs_o_prev_r;

    // Delay line for the first pDELAY-1 stages
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_dly_r <= {LP_STG{1'b0}};
            hs_dly_r <= {LP_STG{1'b0}};
            de_dly_r <= {LP_STG{1'b0}};
            for (int i = 0; i < LP_STG; i++) data_dly_r[i] <= {pDATA_WIDTH{1'b0}};
        end else begin
            vs_dly_r[0]   <= i_vsyn;
            hs_dly_r[0]   <= i_hsyn;
            de_dly_r[0]   <= i_de;
            data_dly_r[0] <= i_video_data;
            for (int i = 1; i < LP_STG; i++) begin
                vs_dly_r[i]   <= vs_dly_r[i-1];
                hs_dly_r[i]   <= hs_dly_r[i-1];
                de_dly_r[i]   <= de_dly_r[i-1];
                data_dly_r[i] <= data_dly_r[i-1];
            end
        end
    end

    // Final delay stage; XOR with the next polarity equals XOR of the delayed raw with inv_r
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vsyn       <= 1'b0;
            o_hsyn       <= 1'b0;
            o_de         <= 1'b0;
            o_video_data <= {pDATA_WIDTH{1'b0}};
        end else begin
            o_vsyn       <= vs_dly_r[LP_STG-1] ^ inv_nxt_s[0];
            o_hsyn       <= hs_dly_r[LP_STG-1] ^ inv_nxt_s[1];
            o_de         <= de_dly_r[LP_STG-1];
            o_video_data <= data_dly_r[LP_STG-1];
        end
    end

    // Polarity decision: longer level within a raw period is the inactive one
    always_comb begin
        inv_nxt_s = inv_r;
        for (int i = 0; i < 2; i++) begin
            if (!i_auto_pol) begin
                inv_nxt_s[i] = i_force_inv[i];
            end else if (rise_s[i] && pol_seen_r[i]) begin
                if (hi_cnt_r[i] > lo_cnt_r[i])      inv_nxt_s[i] = 1'b1;
                else if (lo_cnt_r[i] > hi_cnt_r[i]) inv_nxt_s[i] = 1'b0;
                else                                inv_nxt_s[i] = inv_r[i];
            end else begin
                inv_nxt_s[i] = inv_r[i];
            end
        end
    end

    // Raw high/low period counters (run in forced mode too) and polarity registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            raw_prev_r <= 2'b00;
            pol_seen_r <= 2'b00;
            inv_r      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                hi_cnt_r[i] <= LP_CNT_ZERO;
                lo_cnt_r[i] <= LP_CNT_ZERO;
            end
        end else begin
            raw_prev_r <= raw_s;
            pol_seen_r <= pol_seen_r | rise_s;
            inv_r      <= inv_nxt_s;
            for (int i = 0; i < 2; i++) begin
                if (rise_s[i]) begin
                    hi_cnt_r[i] <= LP_CNT_ONE;
                    lo_cnt_r[i] <= LP_CNT_ZERO;
                end else if (raw_s[i]) begin
                    hi_cnt_r[i] <= sat_inc(hi_cnt_r[i]);
                end else begin
                    lo_cnt_r[i] <= sat_inc(lo_cnt_r[i]);
                end
            end
        end
    end

    // Values a vsync edge would latch; a coincident hsync edge closes the ending frame's last line
    always_comb begin
        h_new_s  = o_h_total;
        v_new_s  = vcnt_r;
        va_new_s = vact_r;
        if (hs_rise_s && h_seen_r) h_new_s = hcnt_r;
        else                       h_new_s = o_h_total;
        if (hs_rise_s) v_new_s = sat_inc(vcnt_r);
        else           v_new_s = vcnt_r;
        if (hs_rise_s && line_de_r) va_new_s = sat_inc(vact_r);
        else                        va_new_s = vact_r;
        lock_match_s = lk_valid_r && (h_new_s == lk_h_r) && (v_new_s == lk_v_r);
    end

    // Line measurement on the normalised hsync/DE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_o_prev_r <= 1'b0;
            h_seen_r    <= 1'b0;
            line_de_r   <= 1'b0;
            hcnt_r      <= LP_CNT_ZERO;
            dcnt_r      <= LP_CNT_ZERO;
            o_h_total   <= LP_CNT_ZERO;
            o_h_active  <= LP_CNT_ZERO;
        end else begin
            hs_o_prev_r <= o_hsyn;
            if (hs_rise_s) begin
                h_seen_r  <= 1'b1;
                hcnt_r    <= LP_CNT_ONE;
                dcnt_r    <= o_de ? LP_CNT_ONE : LP_CNT_ZERO;
                line_de_r <= o_de;
                if (h_seen_r) begin
                    o_h_total  <= hcnt_r;
                    o_h_active <= dcnt_r;
                end else begin
                    o_h_total  <= o_h_total;
                    o_h_active <= o_h_active;
                end
            end else begin
                hcnt_r    <= sat_inc(hcnt_r);
                dcnt_r    <= o_de ? sat_inc(dcnt_r) : dcnt_r;
                line_de_r <= line_de_r | o_de;
            end
        end
    end

    // Frame measurement on the normalised vsync
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_o_prev_r <= 1'b0;
            v_seen_r    <= 1'b0;
            vcnt_r      <= LP_CNT_ZERO;
            vact_r      <= LP_CNT_ZERO;
            o_v_total   <= LP_CNT_ZERO;
            o_v_active  <= LP_CNT_ZERO;
        end else begin
            vs_o_prev_r <= o_vsyn;
            if (vs_rise_s) begin
                v_seen_r <= 1'b1;
                vcnt_r   <= LP_CNT_ZERO;
                vact_r   <= LP_CNT_ZERO;
                if (v_seen_r) begin
                    o_v_total  <= v_new_s;
                    o_v_active <= va_new_s;
                end else begin
                    o_v_total  <= o_v_total;
                    o_v_active <= o_v_active;
                end
            end else begin
                vcnt_r <= v_new_s;
                vact_r <= va_new_s;
            end
        end
    end

    // Lock: a frame matching the previous one sets it; a polarity change also forgets the reference
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lk_valid_r <= 1'b0;
            lk_h_r     <= LP_CNT_ZERO;
            lk_v_r     <= LP_CNT_ZERO;
            o_lock     <= 1'b0;
        end else if (pol_chg_s) begin
            lk_valid_r <= 1'b0;
            o_lock     <= 1'b0;
        end else if (vs_rise_s && v_seen_r) begin
            lk_valid_r <= 1'b1;
            lk_h_r     <= h_new_s;
            lk_v_r     <= v_new_s;
            o_lock     <= lock_match_s;
        end else begin
            o_lock     <= o_lock;
        end
    end

endmodule

// File: tb/tb_video_timing_normalize.sv
// Directed bench: 20-line frames (2 vsync lines, DE on lines 2..17, pixels 15..94),
// hsync 10 cycles at line start; pDELAY=2 and pDELAY=5 instances share the stimulus.
module tb_video_timing_normalize;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsyn = 1'b0, hsyn = 1'b0, de = 1'b0;
    logic [15:0] vdata = 16'd0;
    logic        auto_pol = 1'b1;
    logic [1:0]  force_inv = 2'b00;

    logic        vs_o, hs_o, de_o, vs_inv, hs_inv, lock;
    logic [15:0] data_o;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic        vs_o5, hs_o5, de_o5, vs_inv5, hs_inv5, lock5;
    logic [15:0] data_o5;
    logic [11:0] h_total5, h_active5, v_total5, v_active5;

    int checks = 0;
    int errors = 0;
    int gl = 0, pix = 0, htot = 100, w = 0;
    bit act_low = 1'b0;
    logic [15:0] ramp = 16'd1;
    logic        hs_hist [32];
    logic        vs_hist [32];
    logic        de_hist [32];
    logic [15:0] data_hist [32];

    video_timing_normalize #(.pDATA_WIDTH(16), .pDELAY(2), .pCNT_WIDTH(12)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsyn(vsyn), .i_hsyn(hsyn), .i_de(de),
        .i_video_data(vdata), .i_auto_pol(auto_pol), .i_force_inv(force_inv),
        .o_vsyn(vs_o), .o_hsyn(hs_o), .o_de(de_o), .o_video_data(data_o),
        .o_vs_inv(vs_inv), .o_hs_inv(hs_inv), .o_h_total(h_total), .o_h_active(h_active),
        .o_v_total(v_total), .o_v_active(v_active), .o_lock(lock));

    video_timing_normalize #(.pDATA_WIDTH(16), .pDELAY(5), .pCNT_WIDTH(12)) dut5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_vsyn(vsyn), .i_hsyn(hsyn), .i_de(de),
        .i_video_data(vdata), .i_auto_pol(auto_pol), .i_force_inv(force_inv),
        .o_vsyn(vs_o5), .o_hsyn(hs_o5), .o_de(de_o5), .o_video_data(data_o5),
        .o_vs_inv(vs_inv5), .o_hs_inv(hs_inv5), .o_h_total(h_total5), .o_h_active(h_active5),
        .o_v_total(v_total5), .o_v_active(v_active5), .o_lock(lock5));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        int  l;
        logic hs, vs, d;
        l  = gl % 20;
        hs = (pix < 10);
        vs = (l < 2);
        d  = (l >= 2) && (l < 18) && (pix >= 15) && (pix < 95);
        hsyn  = hs ^ act_low;
        vsyn  = vs ^ act_low;
        de    = d;
        vdata = ramp;
        hs_hist[w & 31]   = hsyn;
        vs_hist[w & 31]   = vsyn;
        de_hist[w & 31]   = d;
        data_hist[w & 31] = ramp;
        @(posedge clk);
        #1;
        w++;
        ramp = ramp + 16'd1;
        pix++;
        if (pix == htot) begin
            pix = 0;
            gl++;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gl = 0;
        pix = 0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if ({vs_o, hs_o, de_o, vs_inv, hs_inv, lock} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 000000", {vs_o, hs_o, de_o, vs_inv, hs_inv, lock}); end
        checks++; if (data_o !== 16'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", data_o); end
        checks++; if ({h_total, h_active, v_total, v_active} !== 48'd0) begin errors++; $display("FAIL reset_meas: got %h expected 0", {h_total, h_active, v_total, v_active}); end
    endtask

    task automatic test_active_high();
        do_reset();
        act_low = 1'b0; auto_pol = 1'b1; htot = 100;
        run_cycles(4000);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL ah_lock_early: got %b expected 0", lock); end
        run_cycles(3000);
        checks++; if ({vs_inv, hs_inv} !== 2'b00) begin errors++; $display("FAIL ah_inv: got %b expected 00", {vs_inv, hs_inv}); end
        checks++; if (h_total !== 12'd100) begin errors++; $display("FAIL ah_h_total: got %0d expected 100", h_total); end
        checks++; if (h_active !== 12'd80) begin errors++; $display("FAIL ah_h_active: got %0d expected 80", h_active); end
        checks++; if (v_total !== 12'd20) begin errors++; $display("FAIL ah_v_total: got %0d expected 20", v_total); end
        checks++; if (v_active !== 12'd16) begin errors++; $display("FAIL ah_v_active: got %0d expected 16", v_active); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL ah_lock: got %b expected 1", lock); end
        checks++; if (h_total5 !== 12'd100) begin errors++; $display("FAIL ah_h_total_d5: got %0d expected 100", h_total5); end
    endtask

    task automatic test_delay();
        for (int i = 0; i < 200; i++) begin
            step();
            checks++;
            if ({de_o, hs_o, data_o} !== {de_hist[(w - 2) & 31], hs_hist[(w - 2) & 31], data_hist[(w - 2) & 31]}) begin
                errors++;
                $display("FAIL delay2: got de=%b hs=%b data=%0d expected de=%b hs=%b data=%0d", de_o, hs_o, data_o,
                         de_hist[(w - 2) & 31], hs_hist[(w - 2) & 31], data_hist[(w - 2) & 31]);
            end
            checks++;
            if ({de_o5, hs_o5, data_o5} !== {de_hist[(w - 5) & 31], hs_hist[(w - 5) & 31], data_hist[(w - 5) & 31]}) begin
                errors++;
                $display("FAIL delay5: got de=%b hs=%b data=%0d expected de=%b hs=%b data=%0d", de_o5, hs_o5, data_o5,
                         de_hist[(w - 5) & 31], hs_hist[(w - 5) & 31], data_hist[(w - 5) & 31]);
            end
        end
    endtask

    task automatic test_force();
        do_reset();
        act_low = 1'b0; auto_pol = 1'b0; force_inv = 2'b10;
        step();
        checks++; if ({vs_inv, hs_inv} !== 2'b01) begin errors++; $display("FAIL force_inv_regs: got vs=%b hs=%b expected vs=0 hs=1", vs_inv, hs_inv); end
        run_cycles(5);
        for (int i = 0; i < 250; i++) begin
            step();
            checks++;
            if ({vs_o, hs_o} !== {vs_hist[(w - 2) & 31], ~hs_hist[(w - 2) & 31]}) begin
                errors++;
                $display("FAIL force_out: got vs=%b hs=%b expected vs=%b hs=%b", vs_o, hs_o, vs_hist[(w - 2) & 31], ~hs_hist[(w - 2) & 31]);
            end
        end
        auto_pol = 1'b1; force_inv = 2'b00;
    endtask

    task automatic test_htotal_change();
        do_reset();
        act_low = 1'b0; htot = 100;
        run_cycles(6000);
        htot = 104;
        run_cycles(20 * 104);
        run_cycles(10 * 104);
        checks++; if (lock !== 1'b0) begin errors++; $display("FAIL chg_lock_clear: got %b expected 0", lock); end
        checks++; if (h_total !== 12'd104) begin errors++; $display("FAIL chg_h_total: got %0d expected 104", h_total); end
        run_cycles(20 * 104);
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL chg_lock_relock: got %b expected 1", lock); end
        checks++; if (v_total !== 12'd20) begin errors++; $display("FAIL chg_v_total: got %0d expected 20", v_total); end
        htot = 100;
    endtask

    task automatic test_saturate();
        do_reset();
        htot = 5000;
        run_cycles(5010);
        checks++; if (h_total !== 12'd4095) begin errors++; $display("FAIL sat_h_total: got %0d expected 4095", h_total); end
        htot = 100;
    endtask

    task automatic test_active_low();
        int highs;
        do_reset();
        act_low = 1'b1; htot = 100;
        run_cycles(13000);
        checks++; if ({vs_inv, hs_inv} !== 2'b11) begin errors++; $display("FAIL al_inv: got %b expected 11", {vs_inv, hs_inv}); end
        checks++; if (lock !== 1'b1) begin errors++; $display("FAIL al_lock: got %b expected 1", lock); end
        checks++; if (h_total !== 12'd100) begin errors++; $display("FAIL al_h_total: got %0d expected 100", h_total); end
        checks++; if (v_total !== 12'd20) begin errors++; $display("FAIL al_v_total: got %0d expected 20", v_total); end
        checks++; if (v_active !== 12'd16) begin errors++; $display("FAIL al_v_active: got %0d expected 16", v_active); end
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (hs_o === 1'b1) highs++;
        end
        checks++; if (highs != 10) begin errors++; $display("FAIL al_hs_width: got %0d expected 10", highs); end
        act_low = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        act_low = 1'b0; htot = 100;
        run_cycles(4350);
        checks++; if ({lock, de_o} !== 2'b11) begin errors++; $display("FAIL mr_pre: got lock/de %b expected 11", {lock, de_o}); end
        rst_n = 1'b0;
        #1;
        checks++; if ({vs_o, hs_o, de_o, vs_inv, hs_inv, lock} !== 6'b0) begin errors++; $display("FAIL mr_ctrl: got %b expected 000000", {vs_o, hs_o, de_o, vs_inv, hs_inv, lock}); end
        checks++; if (data_o !== 16'd0) begin errors++; $display("FAIL mr_data: got %0d expected 0", data_o); end
        checks++; if ({h_total, v_total} !== 24'd0) begin errors++; $display("FAIL mr_meas: got %h expected 0", {h_total, v_total}); end
        run_cycles(3);
        rst_n = 1'b1;
        run_cycles(52);
        checks++; if (h_total !== 12'd0) begin errors++; $display("FAIL mr_first_edge: got %0d expected 0", h_total); end
        run_cycles(100);
        checks++; if (h_total !== 12'd100) begin errors++; $display("FAIL mr_h_total: got %0d expected 100", h_total); end
        checks++; if (h_active !== 12'd80) begin errors++; $display("FAIL mr_h_active: got %0d expected 80", h_active); end
    endtask

    initial begin
        test_reset();
        test_active_high();
        test_delay();
        test_force();
        test_htotal_change();
        test_saturate();
        test_active_low();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
